// File: rtl/dual_slope_ctrl_if.sv
// Switch-driver and result bundle for the dual-slope ADC controller.
// master = controller side, slave = analog front end / result consumer.
interface dual_slope_ctrl_if #(
  parameter int N = 4
);
  logic         inicio;
  logic         cont;
  logic         Vint_z;
  logic         vint_neg;
  logic         rst_s;
  logic         ch_zr;
  logic         ch_vm;
  logic         ch_refp;
  logic         ch_refn;
  logic         busy;
  logic         ld;
  logic [N-1:0] dado;
  logic         neg;
  logic         ovr;

  modport master (
    input  inicio, cont, Vint_z, vint_neg,
    output rst_s, ch_zr, ch_vm, ch_refp, ch_refn,
    output busy, ld, dado, neg, ovr
  );

  modport slave (
    output inicio, cont, Vint_z, vint_neg,
    input  rst_s, ch_zr, ch_vm, ch_refp, ch_refn,
    input  busy, ld, dado, neg, ovr
  );
endinterface

// File: rtl/dual_slope_ctrl.sv
// Dual-slope integrating ADC sequencer: auto-zero, integrate, de-integrate.
// Counts de-integration time internally; all outputs registered Moore decode.
module dual_slope_ctrl #(
  parameter int N         = 4,
  parameter int AZ_CYCLES = 2,
  parameter int TX_CYCLES = 16
) (
  input  logic            ck,
  input  logic            rst,
  dual_slope_ctrl_if.master bus
);
  localparam int TMAX = (AZ_CYCLES > TX_CYCLES) ? AZ_CYCLES : TX_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] AZ_LAST = TW'(AZ_CYCLES - 1);
  localparam logic [TW-1:0] TX_LAST = TW'(TX_CYCLES - 1);
  localparam logic [N-1:0]  CNT_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_AZ, S_INTEG, S_DEINT, S_LOAD
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic          pol_q, pol_d;
  logic [N-1:0]  dado_q, dado_d;
  logic          neg_q, neg_d;
  logic          ovr_q, ovr_d;
  logic          rst_s_q, rst_s_d;
  logic          ch_zr_q, ch_zr_d;
  logic          ch_vm_q, ch_vm_d;
  logic          ch_refp_q, ch_refp_d;
  logic          ch_refn_q, ch_refn_d;
  logic          busy_q, busy_d;
  logic          ld_q, ld_d;

  always_ff @(posedge ck) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      cnt_q     <= '0;
      pol_q     <= 1'b0;
      dado_q    <= '0;
      neg_q     <= 1'b0;
      ovr_q     <= 1'b0;
      rst_s_q   <= 1'b1;
      ch_zr_q   <= 1'b1;
      ch_vm_q   <= 1'b0;
      ch_refp_q <= 1'b0;
      ch_refn_q <= 1'b0;
      busy_q    <= 1'b0;
      ld_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      cnt_q     <= cnt_d;
      pol_q     <= pol_d;
      dado_q    <= dado_d;
      neg_q     <= neg_d;
      ovr_q     <= ovr_d;
      rst_s_q   <= rst_s_d;
      ch_zr_q   <= ch_zr_d;
      ch_vm_q   <= ch_vm_d;
      ch_refp_q <= ch_refp_d;
      ch_refn_q <= ch_refn_d;
      busy_q    <= busy_d;
      ld_q      <= ld_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = '0;
    cnt_d   = cnt_q;
    pol_d   = pol_q;
    dado_d  = dado_q;
    neg_d   = neg_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.inicio) state_d = S_AZ;
      end
      S_AZ: begin
        if (tmr_q == AZ_LAST) state_d = S_INTEG;
        else tmr_d = tmr_q + 1'b1;
      end
      S_INTEG: begin
        if (tmr_q == TX_LAST) begin
          state_d = S_DEINT;
          pol_d   = bus.vint_neg;
          cnt_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DEINT: begin
        // a zero crossing on the final count is a valid full-scale reading
        if (bus.Vint_z) begin
          state_d = S_LOAD;
          dado_d  = cnt_q;
          ovr_d   = 1'b0;
          neg_d   = pol_q;
        end else if (cnt_q == CNT_MAX) begin
          state_d = S_LOAD;
          dado_d  = CNT_MAX;
          ovr_d   = 1'b1;
          neg_d   = pol_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        state_d = bus.cont ? S_AZ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rst_s_d   = 1'b0;
    ch_zr_d   = 1'b0;
    ch_vm_d   = 1'b0;
    ch_refp_d = 1'b0;
    ch_refn_d = 1'b0;
    ld_d      = 1'b0;
    busy_d    = (state_d != S_IDLE);
    unique case (state_d)
      S_IDLE:  begin rst_s_d = 1'b1; ch_zr_d = 1'b1; end
      S_AZ:    ch_zr_d = 1'b1;
      S_INTEG: ch_vm_d = 1'b1;
      S_DEINT: begin ch_refp_d = pol_d; ch_refn_d = ~pol_d; end
      S_LOAD:  begin rst_s_d = 1'b1; ld_d = 1'b1; end
      default: ;
    endcase
  end

  assign bus.rst_s   = rst_s_q;
  assign bus.ch_zr   = ch_zr_q;
  assign bus.ch_vm   = ch_vm_q;
  assign bus.ch_refp = ch_refp_q;
  assign bus.ch_refn = ch_refn_q;
  assign bus.busy    = busy_q;
  assign bus.ld      = ld_q;
  assign bus.dado    = dado_q;
  assign bus.neg     = neg_q;
  assign bus.ovr     = ovr_q;
endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Directed bench for dual_slope_ctrl (N=4, AZ_CYCLES=2, TX_CYCLES=16).
// Each task drives one scenario and checks against hand-computed values.
module tb_dual_slope_ctrl;
  localparam int N = 4;

  logic ck = 1'b0;
  logic rst = 1'b0;
  always #5 ck = ~ck;

  dual_slope_ctrl_if #(.N(N)) bus ();

  dual_slope_ctrl #(
    .N(N), .AZ_CYCLES(2), .TX_CYCLES(16)
  ) dut (
    .ck(ck), .rst(rst), .bus(bus)
  );

  int total  = 0;
  int passed = 0;

  int az_n, vm_n, rp_n, rn_n, ex_n;
  bit conv_done;
  logic [N-1:0] dado_c;
  logic neg_c, ovr_c;

  // Start one conversion and watch it at negedges until the ld strobe.
  // Vint_z is raised during DEINT cycle z_at (0 = never).
  task automatic run_conv(input int z_at, input logic vneg);
    int dn;
    az_n = 0; vm_n = 0; rp_n = 0; rn_n = 0; ex_n = 0;
    dn = 0; conv_done = 0;
    @(negedge ck);
    bus.inicio = 1'b1;
    bus.vint_neg = vneg;
    @(negedge ck);
    bus.inicio = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.ch_zr && !bus.rst_s) az_n++;
      if (bus.ch_vm) vm_n++;
      if (bus.ch_refp) rp_n++;
      if (bus.ch_refn) rn_n++;
      if (int'(bus.ch_zr) + int'(bus.ch_vm) + int'(bus.ch_refp)
          + int'(bus.ch_refn) > 1) ex_n++;
      if (bus.ch_refp || bus.ch_refn) begin
        dn++;
        bus.Vint_z = (dn == z_at);
      end else begin
        bus.Vint_z = 1'b0;
      end
      if (bus.ld) begin
        dado_c = bus.dado;
        neg_c = bus.neg;
        ovr_c = bus.ovr;
        conv_done = 1;
        break;
      end
      @(negedge ck);
    end
    bus.Vint_z = 1'b0;
    total++;
    if (!conv_done) $display("FAIL conv_timeout: no ld within 100 cycles");
    else passed++;
  endtask

  task automatic test_reset();
    bus.inicio = 0; bus.cont = 0; bus.Vint_z = 0; bus.vint_neg = 0;
    rst = 1'b1;
    @(negedge ck);
    @(negedge ck);
    rst = 1'b0;
    total++;
    if ({bus.rst_s, bus.ch_zr} !== 2'b11)
      $display("FAIL reset_sw: got %b exp 11", {bus.rst_s, bus.ch_zr});
    else passed++;
    total++;
    if ({bus.ch_vm, bus.ch_refp, bus.ch_refn} !== 3'b000)
      $display("FAIL reset_ch: got %b exp 000",
               {bus.ch_vm, bus.ch_refp, bus.ch_refn});
    else passed++;
    total++;
    if ({bus.busy, bus.ld} !== 2'b00)
      $display("FAIL reset_busy_ld: got %b exp 00", {bus.busy, bus.ld});
    else passed++;
    total++;
    if ({bus.dado, bus.neg, bus.ovr} !== '0)
      $display("FAIL reset_result: got %0d/%b/%b exp 0/0/0",
               bus.dado, bus.neg, bus.ovr);
    else passed++;
  endtask

  task automatic test_basic();
    run_conv(6, 1'b0);
    total++;
    if (az_n !== 2) $display("FAIL basic_az: got %0d exp 2", az_n);
    else passed++;
    total++;
    if (vm_n !== 16) $display("FAIL basic_vm: got %0d exp 16", vm_n);
    else passed++;
    total++;
    if (rn_n !== 6 || rp_n !== 0)
      $display("FAIL basic_ref: got refn %0d refp %0d exp 6 0", rn_n, rp_n);
    else passed++;
    total++;
    if (ex_n !== 0) $display("FAIL basic_excl: got %0d exp 0", ex_n);
    else passed++;
    total++;
    if ({dado_c, neg_c, ovr_c} !== {4'd5, 1'b0, 1'b0})
      $display("FAIL basic_result: got %0d/%b/%b exp 5/0/0",
               dado_c, neg_c, ovr_c);
    else passed++;
    @(negedge ck);
    total++;
    if ({bus.ld, bus.busy, bus.rst_s, bus.ch_zr} !== 4'b0011)
      $display("FAIL basic_idle: got %b exp 0011",
               {bus.ld, bus.busy, bus.rst_s, bus.ch_zr});
    else passed++;
    total++;
    if (bus.dado !== 4'd5) $display("FAIL basic_hold: got %0d exp 5", bus.dado);
    else passed++;
  endtask

  task automatic test_negative();
    run_conv(1, 1'b1);
    total++;
    if (rp_n !== 1 || rn_n !== 0)
      $display("FAIL neg_ref: got refp %0d refn %0d exp 1 0", rp_n, rn_n);
    else passed++;
    total++;
    if ({dado_c, neg_c, ovr_c} !== {4'd0, 1'b1, 1'b0})
      $display("FAIL neg_result: got %0d/%b/%b exp 0/1/0",
               dado_c, neg_c, ovr_c);
    else passed++;
    @(negedge ck);
    bus.vint_neg = 1'b0;
  endtask

  task automatic test_overrange();
    run_conv(0, 1'b0);
    total++;
    if (rn_n !== 16) $display("FAIL ovr_len: got %0d exp 16", rn_n);
    else passed++;
    total++;
    if ({dado_c, neg_c, ovr_c} !== {4'd15, 1'b0, 1'b1})
      $display("FAIL ovr_result: got %0d/%b/%b exp 15/0/1",
               dado_c, neg_c, ovr_c);
    else passed++;
    @(negedge ck);
    total++;
    if (bus.ld !== 1'b0) $display("FAIL ovr_ld_width: got %b exp 0", bus.ld);
    else passed++;
    run_conv(16, 1'b0);
    total++;
    if (rn_n !== 16) $display("FAIL edge_len: got %0d exp 16", rn_n);
    else passed++;
    total++;
    if ({dado_c, ovr_c} !== {4'd15, 1'b0})
      $display("FAIL edge_result: got %0d/%b exp 15/0", dado_c, ovr_c);
    else passed++;
    @(negedge ck);
  endtask

  task automatic test_continuous();
    int ld_t[3];
    int k, nb, bad_d, dn;
    ld_t = '{0, 0, 0};
    k = 0; nb = 0; bad_d = 0; dn = 0;
    bus.cont = 1'b1;
    @(negedge ck);
    bus.inicio = 1'b1;
    @(negedge ck);
    bus.inicio = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (!bus.busy) nb++;
      if (bus.ch_refp || bus.ch_refn) begin
        dn++;
        bus.Vint_z = (dn == 4);
      end else begin
        dn = 0;
        bus.Vint_z = 1'b0;
      end
      bus.inicio = (c == 30 || c == 50);
      if (bus.ld) begin
        ld_t[k] = c;
        if (bus.dado !== 4'd3) bad_d++;
        k++;
        if (k == 3) begin
          bus.cont = 1'b0;
          break;
        end
      end
      @(negedge ck);
    end
    bus.inicio = 1'b0;
    bus.Vint_z = 1'b0;
    total++;
    if (k !== 3) $display("FAIL cont_count: got %0d exp 3", k);
    else passed++;
    total++;
    if (ld_t[0] !== 22) $display("FAIL cont_first: got %0d exp 22", ld_t[0]);
    else passed++;
    total++;
    if (ld_t[1] - ld_t[0] !== 23)
      $display("FAIL cont_period1: got %0d exp 23", ld_t[1] - ld_t[0]);
    else passed++;
    total++;
    if (ld_t[2] - ld_t[1] !== 23)
      $display("FAIL cont_period2: got %0d exp 23", ld_t[2] - ld_t[1]);
    else passed++;
    total++;
    if (nb !== 0) $display("FAIL cont_busy: got %0d idle cycles exp 0", nb);
    else passed++;
    total++;
    if (bad_d !== 0) $display("FAIL cont_dado: got %0d bad exp 0", bad_d);
    else passed++;
    @(negedge ck);
    total++;
    if (bus.busy !== 1'b0) $display("FAIL cont_stop: got busy %b exp 0", bus.busy);
    else passed++;
  endtask

  task automatic test_abort();
    int seen, ld_cnt, busy_cnt;
    seen = 0; ld_cnt = 0; busy_cnt = 0;
    @(negedge ck);
    bus.inicio = 1'b1;
    @(negedge ck);
    bus.inicio = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.ch_refn) begin
        seen = 1;
        break;
      end
      @(negedge ck);
    end
    total++;
    if (seen !== 1) $display("FAIL abort_reach: got %0d exp 1", seen);
    else passed++;
    @(negedge ck);
    @(negedge ck);
    rst = 1'b1;
    @(negedge ck);
    rst = 1'b0;
    total++;
    if ({bus.busy, bus.rst_s, bus.ch_zr, bus.ch_refn, bus.ld} !== 5'b01100)
      $display("FAIL abort_state: got %b exp 01100",
               {bus.busy, bus.rst_s, bus.ch_zr, bus.ch_refn, bus.ld});
    else passed++;
    total++;
    if ({bus.dado, bus.neg, bus.ovr} !== '0)
      $display("FAIL abort_result: got %0d/%b/%b exp 0/0/0",
               bus.dado, bus.neg, bus.ovr);
    else passed++;
    for (int c = 0; c < 30; c++) begin
      @(negedge ck);
      if (bus.ld) ld_cnt++;
      if (bus.busy) busy_cnt++;
    end
    total++;
    if (ld_cnt !== 0 || busy_cnt !== 0)
      $display("FAIL abort_quiet: got ld %0d busy %0d exp 0 0",
               ld_cnt, busy_cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_overrange();
    test_continuous();
    test_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
